// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the RAM controller arbiter.
//   RAM_ADDR_W / RAM_DATA_W : native RAM controller address and data widths
//   MAX_REQ                 : largest supported requester count
//   req_id_t                : requester index, stored in the read tag FIFO
//   rr_pick                 : cyclic first-one search returning a one-hot grant
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 23;
    localparam int RAM_DATA_W = 32;
    localparam int MAX_REQ    = 4;

    typedef logic [1:0] req_id_t;

    // The search starts at ptr and wraps at n, so only bits [n-1:0] are looked at.
    // ptr must be below n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input req_id_t            ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [1:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 2'((int'(ptr) + k) % n);
            if ((k < n) && !found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ram_tag_fifo.sv
// ram_tag_fifo: synchronous FIFO of requester IDs, one entry per read in flight.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i     : write din_i; accepted when not full, or when full and popping
//   pop_i      : drop the head entry; ignored when empty
//   din_i      : requester ID to store
//   dout_o     : head entry (valid while not empty)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : occupancy, 0..DEPTH
// DEPTH must be a power of two, at least 2.
module ram_tag_fifo
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  req_id_t                  din_i,
    output req_id_t                  dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    req_id_t         mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // At full, a push is accepted only together with a pop: the head is read
    // out this cycle while the freed slot (wptr == rptr) is written at the edge.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM controller port among N_REQ requesters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/rw/addr/data : per-requester command (packed, requester i at slice i)
//   req_ready         : one-hot grant; command accepted when valid & ready
//   rsp_valid         : one-hot read-return strobe, rsp_data shared
//   addr/rw/data_in/in_valid : command to the controller, zero when idle
//   busy              : controller cannot take a command this cycle
//   data_out/out_valid: read data returned by the controller
//   outstanding       : reads in flight (tag FIFO occupancy)
//   err_orphan        : sticky, read data arrived with no read in flight
// Grant and response routing are combinational; only the round-robin pointer,
// the tag FIFO and the orphan flag are state.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int MAX_OUT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_rw,
    input  logic [N_REQ*ADDR_W-1:0]     req_addr,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           addr,
    output logic                        rw,
    output logic [DATA_W-1:0]           data_in,
    output logic                        in_valid,
    input  logic                        busy,
    input  logic [DATA_W-1:0]           data_out,
    input  logic                        out_valid,
    output logic [$clog2(MAX_OUT):0]    outstanding,
    output logic                        err_orphan
);

    req_id_t              rr_ptr_q, rr_ptr_d;
    logic                 err_orphan_q, err_orphan_d;
    logic [MAX_REQ-1:0]   elig4, grant4;
    logic [N_REQ-1:0]     grant;
    req_id_t              win;
    logic                 issue, push, pop;
    logic                 fifo_full, fifo_empty;
    req_id_t              fifo_head;

    ram_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (win),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

    // A return pops the head; gating with rst_n keeps everything quiet in reset.
    assign pop = rst_n & out_valid & ~fifo_empty;

    // A read may be granted at full only when a return frees a slot this cycle.
    always_comb begin
        elig4 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig4[i] = req_valid[i] & (req_rw[i] | ~fifo_full | pop);
        end
    end

    assign grant4    = (rst_n && !busy) ? rr_pick(elig4, rr_ptr_q, N_REQ) : '0;
    assign grant     = grant4[N_REQ-1:0];
    assign issue     = |grant;
    assign req_ready = grant;
    assign in_valid  = issue;

    always_comb begin
        win     = '0;
        addr    = '0;
        rw      = 1'b0;
        data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win     = req_id_t'(i);
                addr    = req_addr[i*ADDR_W +: ADDR_W];
                rw      = req_rw[i];
                data_in = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign push = issue & ~rw;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = pop & (int'(fifo_head) == i);
        end
    end
    assign rsp_data = pop ? data_out : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (int'(win) == N_REQ - 1) ? '0 : req_id_t'(win + 2'd1);
        end
        err_orphan_d = err_orphan_q | (out_valid & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;

endmodule
